// File: rtl/ide_pkg.sv
// Shared IDE definitions: register offsets, buffer window select bit, loader state encoding.
package ide_pkg;

   localparam logic [3:0] IDE_REG_STATUS_IRQ = 4'h0;
   localparam logic [3:0] IDE_REG_IOCONTROL  = 4'h2;
   localparam logic [3:0] IDE_REG_IOPOS      = 4'h3;
   localparam logic [3:0] IDE_REG_STATUS     = 4'h4;
   localparam logic [3:0] IDE_REG_IOTARGET   = 4'h5;

   localparam int IDE_BUF_SEL_BIT = 9;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_FILL,
      LD_SET_CTRL,
      LD_SET_POS,
      LD_SET_TGT,
      LD_SET_STAT,
      LD_DONE
   } ld_state_t;

   // Register space sits below the buffer window, so the select bit is always 0 here.
   function automatic logic [9:0] ide_reg_addr(input logic [3:0] off);
      return {6'd0, off};
   endfunction

endpackage

// File: rtl/ide_buffer_loader_if.sv
// Byte stream input plus the shared SRAM-style port of the IDE interface.
interface ide_buffer_loader_if;

   logic [7:0] src_data;
   logic       src_valid;
   logic       src_ready;
   logic       bus_req;
   logic       bus_gnt;
   logic [9:0] sram_a;
   logic [7:0] sram_d_out;
   logic       sram_cs;
   logic       sram_we;
   logic       sram_oe;

   modport master (
      input  src_data, src_valid, bus_gnt,
      output src_ready, bus_req, sram_a, sram_d_out, sram_cs, sram_we, sram_oe
   );

   modport slave (
      output src_data, src_valid, bus_gnt,
      input  src_ready, bus_req, sram_a, sram_d_out, sram_cs, sram_we, sram_oe
   );

endinterface

// File: rtl/ide_buffer_loader.sv
// Fills the IDE data buffer from a byte stream, then programs iocontrol/iopos/iotarget and status.
// IDE_LOADER_IRQ_EN: final status write goes to the interrupting status offset instead of the silent one.
module ide_buffer_loader
   import ide_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset_,
   input  logic                       start,
   input  logic [7:0]                 len_words,
   input  logic [7:0]                 stat_val,
   input  logic                       abort,
   output logic                       busy,
   output logic                       done,
   output logic                       aborted,
   ide_buffer_loader_if.master        bus
);

`ifdef IDE_LOADER_IRQ_EN
   localparam logic [3:0] STAT_OFF = IDE_REG_STATUS_IRQ;
`else
   localparam logic [3:0] STAT_OFF = IDE_REG_STATUS;
`endif

   ld_state_t  state;
   logic [7:0] len_q;
   logic [7:0] stat_q;
   logic [8:0] byte_idx;
   logic [8:0] last_idx;
   logic       wr_ok;
   logic       wr_fire;

   // 2*W-1 in 9 bits; len_q == 0 wraps to 511, i.e. W = 256.
   assign last_idx = {len_q, 1'b0} - 9'd1;
   assign wr_ok    = bus.bus_gnt & ~abort;

   assign bus.sram_oe = 1'b0;
   assign bus.bus_req = busy & (state != LD_DONE);

   // NOTE: every output gets a default first, so no path through the case can infer a latch.
   always_comb begin
      bus.src_ready  = 1'b0;
      bus.sram_cs    = 1'b0;
      bus.sram_we    = 1'b0;
      bus.sram_a     = '0;
      bus.sram_d_out = '0;
      wr_fire        = 1'b0;
      unique case (state)
         LD_FILL: if (bus.src_valid && wr_ok) begin
            bus.src_ready               = 1'b1;
            wr_fire                     = 1'b1;
            bus.sram_a[IDE_BUF_SEL_BIT] = 1'b1;
            bus.sram_a[8:0]             = byte_idx;
            bus.sram_d_out              = bus.src_data;
         end
         LD_SET_CTRL: if (wr_ok) begin
            wr_fire    = 1'b1;
            bus.sram_a = ide_reg_addr(IDE_REG_IOCONTROL);
         end
         LD_SET_POS: if (wr_ok) begin
            wr_fire    = 1'b1;
            bus.sram_a = ide_reg_addr(IDE_REG_IOPOS);
         end
         LD_SET_TGT: if (wr_ok) begin
            wr_fire        = 1'b1;
            bus.sram_a     = ide_reg_addr(IDE_REG_IOTARGET);
            bus.sram_d_out = len_q - 8'd1;
         end
         LD_SET_STAT: if (wr_ok) begin
            wr_fire        = 1'b1;
            bus.sram_a     = ide_reg_addr(STAT_OFF);
            bus.sram_d_out = stat_q;
         end
         default: ;
      endcase
      bus.sram_cs = wr_fire;
      bus.sram_we = wr_fire;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state    <= LD_IDLE;
         len_q    <= '0;
         stat_q   <= '0;
         byte_idx <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         unique case (state)
            LD_IDLE: if (start) begin
               len_q    <= len_words;
               stat_q   <= stat_val;
               byte_idx <= '0;
               busy     <= 1'b1;
               state    <= LD_FILL;
            end
            LD_DONE: begin
               busy  <= 1'b0;
               state <= LD_IDLE;
            end
            default: if (abort) begin
               busy    <= 1'b0;
               aborted <= 1'b1;
               state   <= LD_IDLE;
            end else if (wr_fire) begin
               unique case (state)
                  LD_FILL: begin
                     byte_idx <= byte_idx + 9'd1;
                     if (byte_idx == last_idx) state <= LD_SET_CTRL;
                  end
                  LD_SET_CTRL: state <= LD_SET_POS;
                  LD_SET_POS:  state <= LD_SET_TGT;
                  LD_SET_TGT:  state <= LD_SET_STAT;
                  LD_SET_STAT: begin
                     done  <= 1'b1;
                     state <= LD_DONE;
                  end
                  default: ;
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ide_buffer_loader.sv
// Directed bench for ide_buffer_loader: full sector, short transfer, flow control, abort, async reset.
module tb_ide_buffer_loader;

   logic       clk = 1'b0;
   logic       reset_ = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] len_words = '0;
   logic [7:0] stat_val = '0;
   logic       busy, done, aborted;

   ide_buffer_loader_if bus ();

   ide_buffer_loader dut (
      .clk       (clk),
      .reset_    (reset_),
      .start     (start),
      .len_words (len_words),
      .stat_val  (stat_val),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [17:0] wr_q[$];
   int          wr_cyc[$];
   logic [7:0]  feed[$];
   int          done_cyc, ab_cyc, flow_viol;
   logic        busy_at_ab, req_at_1, req_at_done;

`ifdef IDE_LOADER_IRQ_EN
   localparam logic [9:0] EXP_STAT_A = 10'h000;
`else
   localparam logic [9:0] EXP_STAT_A = 10'h004;
`endif

   // Cycle 0 is the start cycle; inputs change 1 time unit after posedge, outputs sampled on negedge.
   task automatic run(input logic [7:0] len, input logic [7:0] stat, input bit toggle_valid,
                      input int gnt_lo_from, input int gnt_lo_len, input int abort_at, input int budget);
      int  feed_idx = 0;
      bit  abort_sent = 1'b0;
      wr_q.delete();
      wr_cyc.delete();
      done_cyc = -1; ab_cyc = -1; flow_viol = 0;
      busy_at_ab = 1'bx; req_at_1 = 1'bx; req_at_done = 1'bx;
      for (int c = 0; c < budget; c++) begin
         start         = (c == 0);
         len_words     = len;
         stat_val      = stat;
         bus.src_valid = toggle_valid ? (c % 2 == 1) : 1'b1;
         bus.bus_gnt   = !(c >= gnt_lo_from && c < gnt_lo_from + gnt_lo_len);
         bus.src_data  = (feed_idx < feed.size()) ? feed[feed_idx] : 8'h00;
         abort         = (abort_at >= 0 && feed_idx == abort_at && !abort_sent);
         if (abort) abort_sent = 1'b1;
         @(negedge clk);
         if (bus.sram_cs && bus.sram_we) begin
            wr_q.push_back({bus.sram_a, bus.sram_d_out});
            wr_cyc.push_back(c);
         end
         if ((bus.src_ready && !(bus.src_valid && bus.bus_gnt)) || (bus.sram_cs && !bus.bus_gnt) ||
             (bus.sram_cs && bus.sram_a[9] && !bus.src_ready) || (bus.sram_cs && abort))
            flow_viol++;
         if (bus.src_ready) feed_idx++;
         if (c == 1) req_at_1 = bus.bus_req;
         if (done) begin
            done_cyc    = c;
            req_at_done = bus.bus_req;
         end
         if (aborted) begin
            ab_cyc     = c;
            busy_at_ab = busy;
         end
         @(posedge clk);
         #1;
         if (done_cyc >= 0 || (ab_cyc >= 0 && c >= ab_cyc + 5)) break;
      end
      start = 1'b0;
      abort = 1'b0;
      bus.src_valid = 1'b0;
   endtask

   task automatic load_short();
      feed.delete();
      feed.push_back(8'h11); feed.push_back(8'h22); feed.push_back(8'h33); feed.push_back(8'h44);
   endtask

   task automatic load_sector();
      feed.delete();
      for (int i = 0; i < 512; i++) feed.push_back(8'(i));
   endtask

   initial begin
      logic [17:0] exp_short[8];
      int bad;

      bus.src_data = '0; bus.src_valid = 1'b0; bus.bus_gnt = 1'b0;
      exp_short = '{{10'h200, 8'h11}, {10'h201, 8'h22}, {10'h202, 8'h33}, {10'h203, 8'h44},
                    {10'h002, 8'h00}, {10'h003, 8'h00}, {10'h005, 8'h01}, {EXP_STAT_A, 8'h5A}};

      repeat (2) @(posedge clk);
      #1;
      bus.src_valid = 1'b1; bus.bus_gnt = 1'b1;
      check("reset_outs", {busy, done, aborted, bus.bus_req, bus.src_ready, bus.sram_cs,
                           bus.sram_we, bus.sram_oe}, 0);
      bus.src_valid = 1'b0;
      reset_ = 1'b1;
      @(posedge clk);
      #1;

      // Full sector
      load_sector();
      run(8'd0, 8'h58, 1'b0, -1, 0, -1, 600);
      check("full_wr_count", wr_q.size(), 516);
      bad = 0;
      for (int i = 0; i < 512 && i < wr_q.size(); i++)
         if (wr_q[i] !== {1'b1, 9'(i), 8'(i)} || wr_cyc[i] != i + 1) bad++;
      check("full_buf_bad", bad, 0);
      if (wr_q.size() == 516) check("full_iotarget", wr_q[514], {10'h005, 8'hFF});
      check("full_done_cyc", done_cyc, 517);
      check("full_req_c1", req_at_1, 1);
      check("full_req_done", req_at_done, 0);
      check("full_flow_viol", flow_viol, 0);

      // Short transfer
      load_short();
      run(8'd2, 8'h5A, 1'b0, -1, 0, -1, 60);
      check("short_wr_count", wr_q.size(), 8);
      for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
         check($sformatf("short_wr%0d", i), wr_q[i], exp_short[i]);
         check($sformatf("short_cyc%0d", i), wr_cyc[i], i + 1);
      end
      check("short_done_cyc", done_cyc, 9);
      @(negedge clk);
      check("short_idle_busy", busy, 0);
      @(posedge clk);
      #1;

      // Flow control: valid on odd cycles, grant low in cycles 5..7
      feed.delete();
      for (int i = 0; i < 8; i++) feed.push_back(8'(8'hA0 + i));
      run(8'd4, 8'h50, 1'b1, 5, 3, -1, 100);
      check("flow_viol", flow_viol, 0);
      check("flow_wr_count", wr_q.size(), 12);
      if (wr_q.size() == 12) check("flow_last_byte", wr_q[7], {10'h207, 8'hA7});
      check("flow_done_cyc", done_cyc, 24);

      // Abort after 5 bytes of a full sector
      load_sector();
      run(8'd0, 8'h58, 1'b0, -1, 0, 5, 600);
      check("abort_wr_count", wr_q.size(), 5);
      bad = 0;
      foreach (wr_q[i]) if (wr_q[i][17] !== 1'b1) bad++;
      check("abort_reg_writes", bad, 0);
      check("abort_cyc", ab_cyc, 7);
      check("abort_busy", busy_at_ab, 0);
      check("abort_no_done", done_cyc, -1);
      check("abort_flow_viol", flow_viol, 0);

      // Async reset mid-fill, then a clean restart
      load_short();
      run(8'd2, 8'h5A, 1'b0, -1, 0, -1, 3);
      check("rst_pre_busy", busy, 1);
      bus.src_valid = 1'b1; bus.bus_gnt = 1'b1;
      reset_ = 1'b0;
      #1;
      check("rst_async_outs", {busy, done, aborted, bus.bus_req, bus.src_ready, bus.sram_cs,
                               bus.sram_we, bus.sram_oe}, 0);
      check("rst_async_bus", {bus.sram_a, bus.sram_d_out}, 0);
      bus.src_valid = 1'b0;
      @(posedge clk);
      #1;
      reset_ = 1'b1;
      @(posedge clk);
      #1;
      run(8'd2, 8'h5A, 1'b0, -1, 0, -1, 60);
      check("rst_again_count", wr_q.size(), 8);
      if (wr_q.size() == 8) check("rst_again_first", wr_q[0], {10'h200, 8'h11});
      if (wr_q.size() == 8) check("rst_again_stat", wr_q[7], {EXP_STAT_A, 8'h5A});
      check("rst_again_done", done_cyc, 9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
